// File: rtl/d_ff_stim_checker.sv
// Stimulus source and response checker for one D flip-flop DUT. An LFSR drives d_out,
// and q/q_bar are compared two cycles later against the value that was driven.
module d_ff_stim_checker #(
  parameter int                LFSR_W      = 16,
  parameter logic [LFSR_W-1:0] SEED        = 16'hACE1,
  parameter int                NUM_VECTORS = 256,
  parameter int                CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             d_out,
  input  logic             q_in,
  input  logic             q_bar_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx
);

  typedef enum logic [2:0] {IDLE, PRIME, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  state_t            state, state_nxt;
  logic [LFSR_W-1:0] lfsr;
  logic [CNT_W-1:0]  vec_cnt;
  logic [CNT_W-1:0]  chk_idx;
  logic              drain_cnt;
  logic              drive_valid;
  logic              exp_q;
  logic              exp_valid;
  logic              armed;
  logic              lfsr_fb;
  logic              mismatch;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting toward bit 0
  assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  // Case inequality makes an X/Z on the DUT outputs count as a failure.
  assign mismatch = (q_in !== exp_q) || (q_bar_in !== ~exp_q);

  assign busy = (state == PRIME) || (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment first means every path drives state_nxt, so no latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start && armed) state_nxt = PRIME;
      PRIME:      state_nxt = RUN;
      RUN:        if (vec_cnt == LAST_VEC) state_nxt = DRAIN;
      DRAIN:      if (drain_cnt) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed         <= 1'b0;
      lfsr          <= SEED;
      d_out         <= 1'b0;
      vec_cnt       <= '0;
      chk_idx       <= '0;
      drain_cnt     <= 1'b0;
      drive_valid   <= 1'b0;
      exp_q         <= 1'b0;
      exp_valid     <= 1'b0;
      err_count     <= '0;
      first_err_idx <= ALL_ONES;
    end else begin
      // Blocks a start that arrives on the same edge as reset release.
      armed       <= 1'b1;
      drive_valid <= (state == RUN);
      exp_q       <= d_out;
      exp_valid   <= drive_valid;

      case (state)
        PRIME: begin
          lfsr          <= SEED;
          vec_cnt       <= '0;
          chk_idx       <= '0;
          drain_cnt     <= 1'b0;
          err_count     <= '0;
          first_err_idx <= ALL_ONES;
        end
        RUN: begin
          d_out   <= lfsr[0];
          lfsr    <= {lfsr_fb, lfsr[LFSR_W-1:1]};
          vec_cnt <= vec_cnt + 1'b1;
        end
        DRAIN: drain_cnt <= 1'b1;
        default: ;
      endcase

      if (exp_valid) begin
        chk_idx <= chk_idx + 1'b1;
        if (mismatch) begin
          if (err_count != ALL_ONES)     err_count     <= err_count + 1'b1;
          if (first_err_idx == ALL_ONES) first_err_idx <= chk_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_d_ff_stim_checker.sv
// Directed bench: a behavioural DFF with selectable faults sits beside the checker,
// and each scenario task compares the checker's verdicts with hand-derived values.
module tb_d_ff_stim_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        d_out, q_in, q_bar_in, busy, done, pass;
  logic [15:0] err_count, first_err_idx;
  logic        d_out1, q1, busy1, done1, pass1;
  logic [15:0] err_count1, first_err_idx1;

  int          mode;      // 0 ideal, 1 q stuck-at-0, 2 q_bar tied to q, 3 trojan on vector 100
  logic        q_ff;
  logic        troj;
  int          ecnt;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        ref_bits [256];
  logic        rec      [256];
  logic        saved    [256];
  int          ref_ones;
  int          ref_first_one;

  always #5 clk = ~clk;

  d_ff_stim_checker dut (
    .clk(clk), .reset(reset), .start(start), .d_out(d_out), .q_in(q_in),
    .q_bar_in(q_bar_in), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );

  d_ff_stim_checker #(.NUM_VECTORS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .d_out(d_out1), .q_in(q1),
    .q_bar_in(~q1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err_count1), .first_err_idx(first_err_idx1)
  );

  // After edge s+j of a run started at edge s, ecnt==j+1 and q_ff holds vector j-3.
  always @(posedge clk) begin
    q_ff <= d_out;
    q1   <= d_out1;
    ecnt <= (start && !busy) ? 1 : ecnt + 1;
  end

  assign troj     = (mode == 3) && (ecnt == 104);
  assign q_in     = (mode == 1) ? 1'b0 : (q_ff ^ troj);
  assign q_bar_in = (mode == 2) ? q_in : ~(q_ff ^ troj);

  task automatic build_ref();
    logic [15:0] l;
    l = 16'hACE1;
    ref_ones = 0;
    ref_first_one = -1;
    for (int i = 0; i < 256; i++) begin
      ref_bits[i] = l[0];
      if (l[0]) begin
        ref_ones++;
        if (ref_first_one < 0) ref_first_one = i;
      end
      l = {l[16-16] ^ l[16-14] ^ l[16-13] ^ l[16-11], l[15:1]};
    end
  endtask

  // One full run; lat/lat1 = edges from the start edge until done is seen (-1 on timeout).
  task automatic do_run(input int extra_at, output int lat, output int lat1);
    lat  = -1;
    lat1 = -1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int j = 1; j <= 400; j++) begin
      @(posedge clk); #1;
      start = (j == extra_at);
      if (j >= 2 && j <= 257) rec[j-2] = d_out;
      if (done1 && lat1 < 0) lat1 = j;
      if (done && lat < 0) begin
        lat = j;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; mode = 0;
    #12;
    n_cmp++; if ({d_out, busy, done, pass} !== 4'b0000) begin n_bad++;
      $display("FAIL reset_flags: got %b want 0000", {d_out, busy, done, pass}); end
    n_cmp++; if (err_count !== 16'h0000) begin n_bad++;
      $display("FAIL reset_err: got %h want 0000", err_count); end
    n_cmp++; if (first_err_idx !== 16'hFFFF) begin n_bad++;
      $display("FAIL reset_first: got %h want ffff", first_err_idx); end
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_ideal();
    int lat, lat1, bad_bits;
    mode = 0;
    do_run(0, lat, lat1);
    n_cmp++; if (lat !== 259) begin n_bad++;
      $display("FAIL ideal_latency: got %0d want 259", lat); end
    n_cmp++; if ({pass, busy} !== 2'b10) begin n_bad++;
      $display("FAIL ideal_pass_busy: got %b want 10", {pass, busy}); end
    n_cmp++; if (err_count !== 16'h0000) begin n_bad++;
      $display("FAIL ideal_err: got %h want 0000", err_count); end
    n_cmp++; if (first_err_idx !== 16'hFFFF) begin n_bad++;
      $display("FAIL ideal_first: got %h want ffff", first_err_idx); end
    bad_bits = 0;
    for (int i = 0; i < 256; i++) begin
      if (rec[i] !== ref_bits[i]) bad_bits++;
      saved[i] = rec[i];
    end
    n_cmp++; if (bad_bits !== 0) begin n_bad++;
      $display("FAIL ideal_d_sequence: got %0d wrong bits want 0", bad_bits); end
    n_cmp++; if (d_out !== ref_bits[255]) begin n_bad++;
      $display("FAIL ideal_d_hold: got %b want %b", d_out, ref_bits[255]); end
    // Single-vector instance ran in parallel: 1 prime + 1 run + 2 drain.
    n_cmp++; if (lat1 !== 4) begin n_bad++;
      $display("FAIL single_latency: got %0d want 4", lat1); end
    n_cmp++; if ({pass1, err_count1, first_err_idx1, d_out1} !== {1'b1, 16'h0000, 16'hFFFF, 1'b1}) begin n_bad++;
      $display("FAIL single_result: got %b/%h/%h/%b want 1/0000/ffff/1", pass1, err_count1, first_err_idx1, d_out1); end
  endtask

  task automatic test_stuck0();
    int lat, lat1;
    mode = 1;
    do_run(0, lat, lat1);
    n_cmp++; if (err_count !== 16'(ref_ones)) begin n_bad++;
      $display("FAIL stuck0_err: got %0d want %0d", err_count, ref_ones); end
    n_cmp++; if (first_err_idx !== 16'(ref_first_one)) begin n_bad++;
      $display("FAIL stuck0_first: got %0d want %0d", first_err_idx, ref_first_one); end
    n_cmp++; if ({done, pass} !== 2'b10) begin n_bad++;
      $display("FAIL stuck0_pass: got %b want 10", {done, pass}); end
  endtask

  task automatic test_qbar_tied();
    int lat, lat1;
    mode = 2;
    do_run(0, lat, lat1);
    n_cmp++; if (err_count !== 16'd256) begin n_bad++;
      $display("FAIL qbar_err: got %0d want 256", err_count); end
    n_cmp++; if ({first_err_idx, pass} !== {16'd0, 1'b0}) begin n_bad++;
      $display("FAIL qbar_first_pass: got %0d/%b want 0/0", first_err_idx, pass); end
  endtask

  // Trojan run also carries a stray start pulse mid-RUN, which must not restart it.
  task automatic test_back_to_back();
    int lat, lat1, bad_bits;
    mode = 3;
    do_run(50, lat, lat1);
    n_cmp++; if (lat !== 259) begin n_bad++;
      $display("FAIL trojan_latency: got %0d want 259", lat); end
    n_cmp++; if ({err_count, first_err_idx} !== {16'd1, 16'd100}) begin n_bad++;
      $display("FAIL trojan_result: got %0d/%0d want 1/100", err_count, first_err_idx); end
    mode = 0;
    do_run(0, lat, lat1);
    n_cmp++; if ({pass, err_count, first_err_idx} !== {1'b1, 16'h0000, 16'hFFFF}) begin n_bad++;
      $display("FAIL restart_cleared: got %b/%h/%h want 1/0000/ffff", pass, err_count, first_err_idx); end
    bad_bits = 0;
    for (int i = 0; i < 256; i++) if (rec[i] !== saved[i]) bad_bits++;
    n_cmp++; if (bad_bits !== 0) begin n_bad++;
      $display("FAIL restart_sequence: got %0d differing bits want 0", bad_bits); end
  endtask

  task automatic test_reset_midrun();
    int lat, lat1;
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (52) @(posedge clk);
    #3;
    n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++;
      $display("FAIL midrun_busy: got %b want 10", {busy, done}); end
    reset = 1'b0;
    #1;
    n_cmp++; if ({d_out, busy, done, pass} !== 4'b0000) begin n_bad++;
      $display("FAIL midrun_reset_flags: got %b want 0000", {d_out, busy, done, pass}); end
    n_cmp++; if ({err_count, first_err_idx} !== {16'h0000, 16'hFFFF}) begin n_bad++;
      $display("FAIL midrun_reset_counts: got %h/%h want 0000/ffff", err_count, first_err_idx); end
    repeat (2) @(posedge clk);
    // Release reset with start already high: that edge must not launch a run.
    @(negedge clk); reset = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++;
      $display("FAIL coincident_start: got %b want 00", {busy, done}); end
    mode = 0;
    do_run(0, lat, lat1);
    n_cmp++; if ({lat, pass, err_count} !== {32'd259, 1'b1, 16'h0000}) begin n_bad++;
      $display("FAIL after_reset_run: got %0d/%b/%0d want 259/1/0", lat, pass, err_count); end
  endtask

  initial begin
    build_ref();
    test_reset();
    test_ideal();
    test_stuck0();
    test_qbar_tied();
    test_back_to_back();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
